multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core variant. Sequences one instruction over 3-5 cycles
//  through the shared PC, memory, register file and ALU. Emits ALUOp to alu_dec, which still produces ALUCon.
//  Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
//  Single unified instruction/data memory with a ready handshake.
// PARAMETERS
//  RESET_STATE  4'd0   encoding of FETCH; used for reset and for returning after illegal opcodes
// PORTS
//  clk          in   1   core clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  op           in   7   instr[6:0] from the instruction register
//  zero         in   1   ALU zero flag, combinational, current cycle
//  mem_ready    in   1   memory has completed the current access (read data valid / write accepted)
//  pc_write     out  1   PC register enable
//  adr_src      out  1   memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1   memory write strobe
//  mem_req      out  1   memory access request
//  ir_write     out  1   instruction register and OldPC enable
//  result_src   out  2   result mux select: 00=ALUOut, 01=Data, 10=ALUResult
//  alu_src_a    out  2   ALU A select: 00=PC, 01=OldPC, 10=rs1
//  alu_src_b    out  2   ALU B select: 00=rs2, 01=ImmExt, 10=const 4
//  imm_src      out  2   immediate format: 00=I, 01=S, 10=B, 11=J
//  alu_op       out  2   to alu_dec: 00=add, 01=sub, 10=funct-decoded
//  reg_write    out  1   register file write enable
//  illegal      out  1   one-cycle pulse when DECODE sees an unsupported opcode
// BEHAVIOUR
//  - States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
//  - Reset: while rst_n=0, state=FETCH and every enable is 0 (pc_write, mem_write, mem_req, ir_write,
//    reg_write, illegal). Muxes reset to 0 and alu_op to 00.
//  - Reset asserted mid-instruction aborts it immediately, including any pending memory write.
//    The first cycle after release is FETCH.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
//    ir_write and pc_write are asserted only when mem_ready=1; state holds in FETCH until then.
//  - DECODE (1 cycle): alu_src_a=01, alu_src_b=01, alu_op=00, so the branch/jump target goes to ALUOut.
//    Next state by op:
//      0000011/0100011 -> MEMADR
//      0110011 -> EXECR
//      0010011 -> EXECI
//      1100011 -> BEQ
//      1101111 -> JAL
//      any other op -> FETCH with illegal=1 and no state updated
//  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. op[5]=0 -> MEMREAD, else -> MEMWRITE.
//  - MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then -> MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, adr_src=1. mem_write=1 every cycle of the state; it is a level, not a
//    one-cycle pulse. Holds until mem_ready, then -> FETCH.
//  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
//  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00 -> FETCH.
//    pc_write = zero, sampled combinationally in that same cycle.
//  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB, which writes PC+4 to rd.
//  - imm_src is decoded purely from op and is valid in every state:
//    lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
//  - Instruction latency in cycles with mem_ready tied high:
//    lw=5, sw=4, R/I=4, beq=3, jal=4. Each wait cycle on mem_ready adds one cycle.
//  - Only FETCH, MEMREAD and MEMWRITE ever sample mem_ready; it is ignored in every other state.
//  - Unreachable state encodings return to FETCH with all enables 0.
// STRUCTURE
//  - Shared package core_pkg holds:
//    - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
//    - ALUOp and ImmSrc encodings
//    - the state enum
//  - One sub-module: imm_src_dec, a combinational op -> imm_src decoder.
//  - FSM: a registered state plus a combinational next-state/output block. Outputs are Moore, except
//    that pc_write and ir_write are gated by mem_ready and zero.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles, release. Required: state=FETCH, all enables 0 while in reset;
//    first post-reset cycle has mem_req=1, adr_src=0.
//  - lw, op=0000011, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
//    reg_write=1 with result_src=01 in cycle 5 only.
//  - sw with mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for 3 cycles, then FETCH.
//    reg_write is never asserted.
//  - beq, op=1100011:
//    - zero=1 -> pc_write=1 in the BEQ cycle
//    - zero=0 -> pc_write=0
//    - both cases: alu_op=01, 3 cycles total
//  - R-type then I-type, op=0110011 then 0010011: alu_op=10 in EXECR/EXECI, alu_src_b 00 vs 01,
//    4 cycles each. jal (op=1101111): pc_write in JAL, reg_write in ALUWB.
//  - Illegal op=1111111: illegal=1 for exactly one cycle at DECODE, then FETCH.
//    Async reset asserted during MEMWRITE drops mem_write in the same cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// ALUOp / ImmSrc / mux encodings and the main FSM state enum.
package core_pkg;

  // Opcodes handled by the multi-cycle core
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp encodings consumed by alu_dec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Main FSM states; encodings 11..15 are unreachable
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // True for the load/store opcodes that share the address phase
  function automatic logic is_mem_op(input logic [6:0] op);
    is_mem_op = (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Combinational opcode -> immediate format decoder. Independent of the FSM
// state so the immediate is valid in every cycle of the instruction.
module imm_src_dec
  import core_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  // Select immediate format from the opcode; unknown opcodes use I-format
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LW:   imm_src = IMM_I;
      OP_I:    imm_src = IMM_I;
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Sequences each instruction
// over 3-5 cycles through the shared PC, unified memory, register file and
// ALU. Outputs decode from the state register; pc_write and ir_write are
// additionally qualified by mem_ready / zero in the cycle they are used.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal
);

  localparam state_t RESET_STATE_C = state_t'(RESET_STATE);

  state_t state_r;
  state_t state_next_s;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  // State register; reset aborts any instruction and returns to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE_C;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode; everything forced idle while in reset so
  // an in-flight memory write is dropped as soon as rst_n falls
  always_comb begin
    state_next_s = RESET_STATE_C;
    pc_write     = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    mem_req      = 1'b0;
    ir_write     = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALUOP_ADD;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    if (!rst_n) begin
      state_next_s = RESET_STATE_C;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req    = 1'b1;
          adr_src    = 1'b0;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALUOP_ADD;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          state_next_s = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          // OldPC + imm lands in ALUOut for a following BEQ/JAL
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          if (is_mem_op(op)) begin
            state_next_s = S_MEMADR;
          end else begin
            case (op)
              OP_R:   state_next_s = S_EXECR;
              OP_I:   state_next_s = S_EXECI;
              OP_BEQ: state_next_s = S_BEQ;
              OP_JAL: state_next_s = S_JAL;
              default: begin
                illegal      = 1'b1;
                state_next_s = RESET_STATE_C;
              end
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_IMM;
          alu_op       = ALUOP_ADD;
          state_next_s = op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req      = 1'b1;
          adr_src      = 1'b1;
          state_next_s = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          result_src   = RES_DATA;
          reg_write    = 1'b1;
          state_next_s = S_FETCH;
        end
        S_MEMWRITE: begin
          // Write strobe is held for the whole access, not pulsed
          mem_req      = 1'b1;
          adr_src      = 1'b1;
          mem_write    = 1'b1;
          state_next_s = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECR: begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_RS2;
          alu_op       = ALUOP_FUNCT;
          state_next_s = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_IMM;
          alu_op       = ALUOP_FUNCT;
          state_next_s = S_ALUWB;
        end
        S_ALUWB: begin
          result_src   = RES_ALUOUT;
          reg_write    = 1'b1;
          state_next_s = S_FETCH;
        end
        S_BEQ: begin
          // Branch target already in ALUOut; take it only if rs1 == rs2
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_RS2;
          alu_op       = ALUOP_SUB;
          result_src   = RES_ALUOUT;
          pc_write     = zero;
          state_next_s = S_FETCH;
        end
        S_JAL: begin
          // PC <- target from ALUOut while the ALU forms OldPC + 4 for rd
          alu_src_a    = SRCA_OLDPC;
          alu_src_b    = SRCB_FOUR;
          alu_op       = ALUOP_ADD;
          result_src   = RES_ALUOUT;
          pc_write     = 1'b1;
          state_next_s = S_ALUWB;
        end
        default: begin
          state_next_s = RESET_STATE_C;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of per-cycle input/expected
// output records plus hand-written sequences for reset abort and imm_src.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       mem_req;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       illegal;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .mem_req    (mem_req),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       mem_req;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    out_t       exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  out_t e_rst, e_fetch, e_fwait, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr;
  out_t e_exr, e_exi, e_awb, e_beqt, e_beqn, e_jal;

  function automatic out_t mk(input logic pc, input logic adr, input logic mw,
                              input logic mr, input logic ir, input logic [1:0] rs,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] aop, input logic rw, input logic il);
    mk = {pc, adr, mw, mr, ir, rs, a, b, aop, rw, il};
  endfunction

  function automatic out_t actual();
    actual = {pc_write, adr_src, mem_write, mem_req, ir_write, result_src,
              alu_src_a, alu_src_b, alu_op, reg_write, illegal};
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic z,
                     input logic rdy, input out_t e, input string n);
    vec_t v;
    v.rst_n = r; v.op = o; v.zero = z; v.mem_ready = rdy; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic compare(input string n, input out_t e);
    out_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc,adr,mw,mr,ir,rs,a,b,aop,rw,il=%b want %b", n, a, e);
    end
  endtask

  // One clock step: drive at the falling edge, compare 1 time unit later
  task automatic step(input logic r, input logic [6:0] o, input logic z,
                      input logic rdy, input out_t e, input string n);
    @(negedge clk);
    rst_n = r; op = o; zero = z; mem_ready = rdy;
    #1;
    compare(n, e);
  endtask

  logic [6:0] imm_ops [7];
  logic [1:0] imm_exp [7];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;

    //               pc    adr   mw    mr    ir    rs     a      b      aop    rw    il
    e_rst   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_fetch = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    e_fwait = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    e_dec   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    e_ill   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
    e_madr  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    e_mrd   = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_mwb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    e_mwr   = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_exr   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);
    e_exi   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0);
    e_awb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    e_beqt  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
    e_beqn  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
    e_jal   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);

    // Reset held 3 cycles with mem_ready high: nothing may be enabled
    add(1'b0, LW, 1'b0, 1'b1, e_rst, "reset0");
    add(1'b0, LW, 1'b0, 1'b1, e_rst, "reset1");
    add(1'b0, LW, 1'b0, 1'b1, e_rst, "reset2");
    // First post-reset cycle is FETCH; wait one cycle on memory
    add(1'b1, LW, 1'b0, 1'b0, e_fwait, "fetch_wait");
    // lw with one MEMREAD wait cycle; mem_ready low in DECODE/MEMADR ignored
    add(1'b1, LW, 1'b0, 1'b1, e_fetch, "lw_fetch");
    add(1'b1, LW, 1'b0, 1'b0, e_dec,   "lw_decode");
    add(1'b1, LW, 1'b0, 1'b0, e_madr,  "lw_memadr");
    add(1'b1, LW, 1'b0, 1'b0, e_mrd,   "lw_memread_wait");
    add(1'b1, LW, 1'b0, 1'b1, e_mrd,   "lw_memread");
    add(1'b1, LW, 1'b0, 1'b1, e_mwb,   "lw_memwb");
    // lw with mem_ready tied high: 5 cycles
    add(1'b1, LW, 1'b0, 1'b1, e_fetch, "lw2_fetch");
    add(1'b1, LW, 1'b0, 1'b1, e_dec,   "lw2_decode");
    add(1'b1, LW, 1'b0, 1'b1, e_madr,  "lw2_memadr");
    add(1'b1, LW, 1'b0, 1'b1, e_mrd,   "lw2_memread");
    add(1'b1, LW, 1'b0, 1'b1, e_mwb,   "lw2_memwb");
    // sw, memory stalls two cycles: mem_write level for 3 cycles
    add(1'b1, SW, 1'b0, 1'b1, e_fetch, "sw_fetch");
    add(1'b1, SW, 1'b0, 1'b1, e_dec,   "sw_decode");
    add(1'b1, SW, 1'b0, 1'b1, e_madr,  "sw_memadr");
    add(1'b1, SW, 1'b0, 1'b0, e_mwr,   "sw_memwrite1");
    add(1'b1, SW, 1'b0, 1'b0, e_mwr,   "sw_memwrite2");
    add(1'b1, SW, 1'b0, 1'b1, e_mwr,   "sw_memwrite3");
    // beq taken (zero=1), then not taken; zero in DECODE has no effect
    add(1'b1, BQ, 1'b0, 1'b1, e_fetch, "beqt_fetch");
    add(1'b1, BQ, 1'b0, 1'b1, e_dec,   "beqt_decode");
    add(1'b1, BQ, 1'b1, 1'b1, e_beqt,  "beqt_beq");
    add(1'b1, BQ, 1'b1, 1'b1, e_fetch, "beqn_fetch");
    add(1'b1, BQ, 1'b1, 1'b1, e_dec,   "beqn_decode");
    add(1'b1, BQ, 1'b0, 1'b1, e_beqn,  "beqn_beq");
    // R-type then I-type
    add(1'b1, RT, 1'b0, 1'b1, e_fetch, "r_fetch");
    add(1'b1, RT, 1'b0, 1'b1, e_dec,   "r_decode");
    add(1'b1, RT, 1'b0, 1'b1, e_exr,   "r_execr");
    add(1'b1, RT, 1'b0, 1'b1, e_awb,   "r_aluwb");
    add(1'b1, IT, 1'b0, 1'b1, e_fetch, "i_fetch");
    add(1'b1, IT, 1'b0, 1'b1, e_dec,   "i_decode");
    add(1'b1, IT, 1'b0, 1'b1, e_exi,   "i_execi");
    add(1'b1, IT, 1'b0, 1'b1, e_awb,   "i_aluwb");
    // jal
    add(1'b1, JL, 1'b0, 1'b1, e_fetch, "jal_fetch");
    add(1'b1, JL, 1'b0, 1'b1, e_dec,   "jal_decode");
    add(1'b1, JL, 1'b0, 1'b1, e_jal,   "jal_jal");
    add(1'b1, JL, 1'b0, 1'b1, e_awb,   "jal_aluwb");
    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
    add(1'b1, BAD, 1'b0, 1'b1, e_fetch, "ill_fetch");
    add(1'b1, BAD, 1'b0, 1'b1, e_ill,   "ill_decode");
    add(1'b1, BAD, 1'b0, 1'b1, e_fetch, "ill_refetch");
    add(1'b1, BAD, 1'b0, 1'b1, e_ill,   "ill_decode2");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].mem_ready,
           vecs[i].exp, vecs[i].name);
    end

    // Async reset in the middle of a stalled MEMWRITE drops the strobe at once
    step(1'b1, SW, 1'b0, 1'b1, e_fetch, "abort_fetch");
    step(1'b1, SW, 1'b0, 1'b1, e_dec,   "abort_decode");
    step(1'b1, SW, 1'b0, 1'b1, e_madr,  "abort_memadr");
    step(1'b1, SW, 1'b0, 1'b0, e_mwr,   "abort_memwrite");
    #2;
    rst_n = 1'b0;
    #1;
    compare("abort_async_drop", e_rst);
    step(1'b0, SW, 1'b0, 1'b1, e_rst,   "abort_hold");
    step(1'b1, SW, 1'b0, 1'b1, e_fetch, "abort_refetch");
    step(1'b1, SW, 1'b0, 1'b1, e_dec,   "abort_redecode");
    step(1'b1, SW, 1'b0, 1'b1, e_madr,  "abort_rememadr");
    step(1'b1, SW, 1'b0, 1'b1, e_mwr,   "abort_rememwrite");

    // imm_src is a pure function of op
    imm_ops[0] = LW;  imm_exp[0] = 2'b00;
    imm_ops[1] = IT;  imm_exp[1] = 2'b00;
    imm_ops[2] = SW;  imm_exp[2] = 2'b01;
    imm_ops[3] = BQ;  imm_exp[3] = 2'b10;
    imm_ops[4] = JL;  imm_exp[4] = 2'b11;
    imm_ops[5] = RT;  imm_exp[5] = 2'b00;
    imm_ops[6] = BAD; imm_exp[6] = 2'b00;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      op = imm_ops[k];
      #1;
      checks++;
      if (imm_src !== imm_exp[k]) begin
        errors++;
        $display("FAIL imm_src op=%b: got %b want %b", imm_ops[k], imm_src, imm_exp[k]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
